// File: rtl/mips_perf_dump.sv
// rtl/mips_perf_dump.sv - snapshot eight perf counters and stream them as a checksummed byte frame
module mips_perf_dump (
  input  logic        mips_cpu_clk,
  input  logic        mips_cpu_reset,
  input  logic [31:0] cycle_cnt,
  input  logic [31:0] inst_cnt,
  input  logic [31:0] br_cnt,
  input  logic [31:0] ld_cnt,
  input  logic [31:0] st_cnt,
  input  logic [31:0] user1_cnt,
  input  logic [31:0] user2_cnt,
  input  logic [31:0] user3_cnt,
  input  logic        dump_req,
  output logic        dump_valid,
  output logic [7:0]  dump_data,
  output logic        dump_last,
  input  logic        dump_ready,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [1:0] {IDLE, HEAD, DATA, CSUM} state_t;

  state_t       state, state_nxt;
  logic [255:0] snapshot;
  logic [7:0]   csum;
  logic [4:0]   byte_idx;
  logic [7:0]   data_byte;
  logic         accept;
  logic         start;

  assign busy      = (state != IDLE);
  assign accept    = dump_valid && dump_ready;
  assign start     = (state == IDLE) && dump_req;
  assign data_byte = snapshot[{byte_idx, 3'b000} +: 8];

  // Outputs are decoded from registered state only, so data/last hold during stalls
  always_comb begin
    state_nxt  = state;
    dump_valid = 1'b0;
    dump_data  = 8'h00;
    dump_last  = 1'b0;
    case (state)
      IDLE: begin
        if (dump_req) state_nxt = HEAD;
      end
      HEAD: begin
        dump_valid = 1'b1;
        dump_data  = HEADER;
        if (dump_ready) state_nxt = DATA;
      end
      DATA: begin
        dump_valid = 1'b1;
        dump_data  = data_byte;
        if (dump_ready && (byte_idx == 5'd31)) state_nxt = CSUM;
      end
      CSUM: begin
        dump_valid = 1'b1;
        dump_data  = csum;
        dump_last  = 1'b1;
        if (dump_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mips_cpu_clk or posedge mips_cpu_reset) begin
    if (mips_cpu_reset) begin
      state    <= IDLE;
      snapshot <= '0;
      csum     <= 8'h00;
      byte_idx <= 5'd0;
      drop_cnt <= 8'h00;
    end else begin
      state <= state_nxt;
      if (start) begin
        snapshot <= {user3_cnt, user2_cnt, user1_cnt, st_cnt,
                     ld_cnt, br_cnt, inst_cnt, cycle_cnt};
        csum     <= 8'h00;
      end
      if ((state == HEAD) && accept) byte_idx <= 5'd0;
      if ((state == DATA) && accept) begin
        byte_idx <= byte_idx + 5'd1;
        csum     <= csum + data_byte;
      end
      // Requests during a frame are counted, never queued
      if (dump_req && busy && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mips_perf_dump.sv
// tb/tb_mips_perf_dump.sv - directed vector bench for mips_perf_dump
`timescale 1ns/1ps
module tb_mips_perf_dump;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0][31:0] cnt;
  logic             dump_req, dump_ready;
  logic             dump_valid, dump_last, busy;
  logic [7:0]       dump_data, drop_cnt;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_drop;

  always #5 clk = ~clk;

  mips_perf_dump dut (
    .mips_cpu_clk   (clk),
    .mips_cpu_reset (rst),
    .cycle_cnt      (cnt[0]),
    .inst_cnt       (cnt[1]),
    .br_cnt         (cnt[2]),
    .ld_cnt         (cnt[3]),
    .st_cnt         (cnt[4]),
    .user1_cnt      (cnt[5]),
    .user2_cnt      (cnt[6]),
    .user3_cnt      (cnt[7]),
    .dump_req       (dump_req),
    .dump_valid     (dump_valid),
    .dump_data      (dump_data),
    .dump_last      (dump_last),
    .dump_ready     (dump_ready),
    .busy           (busy),
    .drop_cnt       (drop_cnt)
  );

  typedef struct {
    logic [7:0][31:0] cnts;
    int               mode;
    bit               scramble;
    bit               drops;
    logic [7:0]       csum;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    logic [7:0] exp_b[34];
    logic [7:0] got[$];
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    int         busy_cycles;
    int         cyc;
    int         n;
    bit         done;
    exp_b[0] = 8'hA5;
    for (int k = 0; k < 32; k++) exp_b[k+1] = v.cnts[k/4][8*(k%4) +: 8];
    exp_b[33] = v.csum;
    got.delete();
    @(posedge clk); #1;
    cnt = v.cnts;
    dump_req = 1'b1;
    dump_ready = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    prev_stall = 1'b0; prev_data = 8'h00; prev_last = 1'b0;
    busy_cycles = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 400) begin
      dump_ready = (v.mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (v.scramble) for (int i = 0; i < 8; i++) cnt[i] = $urandom();
      @(negedge clk);
      if (busy) busy_cycles++;
      check({tag, " valid_mid_frame"}, dump_valid, 1);
      if (prev_stall) begin
        check({tag, " stall_data"}, dump_data, prev_data);
        check({tag, " stall_last"}, dump_last, prev_last);
      end
      prev_stall = dump_valid && !dump_ready;
      prev_data  = dump_data;
      prev_last  = dump_last;
      if (dump_valid && dump_ready) begin
        n = got.size();
        if (n < 34) begin
          check($sformatf("%s byte%0d", tag, n), dump_data, exp_b[n]);
          check($sformatf("%s last%0d", tag, n), dump_last, (n == 33));
        end
        got.push_back(dump_data);
        done = dump_last || (n >= 33);
        if (v.drops && done) dump_req = 1'b1;
      end
      if (v.drops && (cyc == 5 || cyc == 20)) dump_req = 1'b1;
      @(posedge clk); #1;
      dump_req = 1'b0;
      cyc++;
    end
    check({tag, " frame_len"}, got.size(), 34);
    if (v.mode == 0) check({tag, " busy_cycles"}, busy_cycles, 34);
    if (v.drops) exp_drop = (exp_drop > 8'hFC) ? 8'hFF : exp_drop + 8'd3;
    @(negedge clk);
    check({tag, " busy_after"}, busy, 0);
    check({tag, " valid_after"}, dump_valid, 0);
    repeat (3) @(negedge clk);
    check({tag, " no_second_frame"}, busy, 0);
    check({tag, " drop_cnt"}, drop_cnt, exp_drop);
  endtask

  initial begin : main
    int  nbytes;
    int  last_start;
    int  nstarts;
    logic prev_busy;
    bit  seen_last;

    vecs[0].cnts = '0; vecs[0].cnts[0] = 32'h0000_0100;
    vecs[0].mode = 0; vecs[0].scramble = 0; vecs[0].drops = 0; vecs[0].csum = 8'h01;
    for (int i = 0; i < 8; i++) vecs[1].cnts[i] = 32'h0403_0201 + 32'h0404_0404 * i;
    vecs[1].mode = 0; vecs[1].scramble = 0; vecs[1].drops = 0; vecs[1].csum = 8'h10;
    vecs[2] = vecs[0]; vecs[2].mode = 1;
    vecs[3].cnts = {8{32'hFFFF_FFFF}};
    vecs[3].mode = 1; vecs[3].scramble = 0; vecs[3].drops = 0; vecs[3].csum = 8'hE0;
    vecs[4].cnts = {8{32'h8080_8080}};
    vecs[4].mode = 0; vecs[4].scramble = 0; vecs[4].drops = 0; vecs[4].csum = 8'h00;
    vecs[5] = vecs[1]; vecs[5].scramble = 1; vecs[5].drops = 1;

    rst = 1'b1; cnt = '0; dump_req = 1'b0; dump_ready = 1'b0; exp_drop = 8'h00;
    repeat (2) @(negedge clk);
    check("reset valid", dump_valid, 0);
    check("reset data", dump_data, 8'h00);
    check("reset last", dump_last, 0);
    check("reset busy", busy, 0);
    check("reset drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    dump_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("idle ignores ready", dump_valid, 0);

    for (int t = 0; t < 6; t++) run_frame(vecs[t], $sformatf("vec%0d", t));

    // Long stall in HEAD with a request held high the whole time
    @(posedge clk); #1;
    cnt = vecs[0].cnts; dump_req = 1'b1; dump_ready = 1'b0;
    repeat (301) @(posedge clk);
    #1; dump_req = 1'b0;
    exp_drop = 8'hFF;
    @(negedge clk);
    check("sat drop_cnt", drop_cnt, 8'hFF);
    check("sat valid held", dump_valid, 1);
    check("sat header held", dump_data, 8'hA5);
    dump_ready = 1'b1;
    nbytes = 0; seen_last = 1'b0;
    for (int c = 0; c < 100 && !seen_last; c++) begin
      if (dump_valid && dump_ready) begin
        nbytes++;
        seen_last = dump_last;
      end
      @(negedge clk);
    end
    check("sat frame_len", nbytes, 34);
    check("sat busy_after", busy, 0);

    // Reset in the middle of a frame
    @(posedge clk); #1;
    cnt = vecs[0].cnts; dump_req = 1'b1; dump_ready = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    repeat (12) @(posedge clk);
    #2; rst = 1'b1; #1;
    check("rst valid", dump_valid, 0);
    check("rst busy", busy, 0);
    check("rst drop_cnt", drop_cnt, 0);
    check("rst data", dump_data, 8'h00);
    check("rst last", dump_last, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_drop = 8'h00;
    repeat (2) @(negedge clk);
    check("rst no restart", busy, 0);
    run_frame(vecs[1], "after_reset");

    // Request held high continuously
    @(posedge clk); #1;
    dump_ready = 1'b1; dump_req = 1'b1;
    prev_busy = 1'b0; last_start = -1; nstarts = 0;
    for (int c = 0; c < 320; c++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        if (last_start >= 0) check("b2b spacing", c - last_start, 35);
        last_start = c;
        nstarts++;
      end
      prev_busy = busy;
    end
    dump_req = 1'b0;
    check("b2b enough frames", (nstarts >= 8), 1);
    check("b2b drop saturated", drop_cnt, 8'hFF);
    for (int c = 0; c < 50 && busy; c++) @(negedge clk);
    check("b2b drains", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
